// File: rtl/rr_mux4_sched.sv
// Round-robin scheduler sharing one mux4_to_1 datapath between four valid/ready
// requesters, feeding a single-entry registered output stage.
module rr_mux4_sched #(
    parameter int unsigned DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      req_valid,
    input  logic [4*DW-1:0] req_data,
    output logic [3:0]      req_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [1:0]      out_src,
    input  logic            out_ready,
    output logic [1:0]      sel,
    output logic            busy
);

    localparam int unsigned NREQ = 4;
    localparam int unsigned IW   = 2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_sel;
    logic [IW-1:0]   r_src;
    logic [DW-1:0]   r_data;
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_idx;
    logic            w_any;
    logic            w_can_load;
    logic            w_xfer;

    // First valid requester scanning ptr, ptr+1, ... with natural mod-4 wrap
    always_comb begin : winner_scan
        w_any = 1'b0;
        w_win = r_ptr;
        w_idx = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            w_idx = r_ptr + IW'(k);
            if (!w_any && req_valid[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    // The output stage can take a word when empty or when its word leaves now
    assign w_can_load = (r_state == ST_EMPTY) || out_ready;
    assign w_xfer     = w_any && w_can_load && rst_n;
    assign req_ready  = w_xfer ? (NREQ'(1) << w_win) : '0;

    always_comb begin : fsm_next
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_xfer) w_state_nxt = ST_FULL;
            ST_FULL:  if (out_ready && !w_xfer) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : fsm_reg
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output stage and pointer update only on an accepted word
    always_ff @(posedge clk or negedge rst_n) begin : data_reg
        if (!rst_n) begin
            r_data <= '0;
            r_src  <= '0;
            r_sel  <= '0;
            r_ptr  <= '0;
        end else if (w_xfer) begin
            r_data <= req_data[32'(w_win) * DW +: DW];
            r_src  <= w_win;
            r_sel  <= w_win;
            r_ptr  <= w_win + IW'(1);
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign busy      = out_valid;
    assign out_data  = r_data;
    assign out_src   = r_src;
    assign sel       = r_sel;

endmodule

// File: tb/tb_rr_mux4_sched.sv
// Bench for rr_mux4_sched: hand-derived grant table, randomized traffic against a
// scoreboard queue, and async reset corner cases.
`timescale 1ns/1ps
module tb_rr_mux4_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        out_ready;
    logic [1:0]  sel;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] s;
    } word_t;

    typedef struct {
        logic [3:0]  rv;
        logic        ord;
        logic [31:0] d;
        logic [3:0]  exp_ready;
    } vec_t;

    word_t      q[$];
    logic [1:0] m_ptr;
    logic [1:0] m_sel;
    vec_t       tbl[24];

    rr_mux4_sched #(.DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare this cycle's outputs with the model, then advance the model as the edge will
    task automatic check_cycle();
        logic [3:0]  er;
        logic [1:0]  w;
        logic [1:0]  idx;
        logic        any;
        logic        can;
        logic [31:0] tmp;
        can = (q.size() == 0) || out_ready;
        any = 1'b0;
        w   = m_ptr;
        for (int k = 0; k < 4; k++) begin
            idx = m_ptr + 2'(k);
            if (!any && req_valid[idx]) begin
                any = 1'b1;
                w   = idx;
            end
        end
        er = (any && can) ? (4'b0001 << w) : 4'b0000;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("busy", 32'(busy), 32'(q.size() != 0));
        chk("sel", 32'(sel), 32'(m_sel));
        if (q.size() != 0) begin
            chk("out_data", 32'(out_data), 32'(q[0].d));
            chk("out_src", 32'(out_src), 32'(q[0].s));
            if (out_ready) void'(q.pop_front());
        end
        if (any && can) begin
            tmp = req_data >> (8 * w);
            q.push_back('{d: tmp[7:0], s: w});
            m_ptr = w + 2'd1;
            m_sel = w;
        end
    endtask

    task automatic tick(input logic [3:0] rv, input logic ord, input logic [31:0] d);
        @(posedge clk);
        #1;
        req_valid = rv;
        out_ready = ord;
        req_data  = d;
        @(negedge clk);
        check_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        // fairness, backpressure, wrap, drain, single requester
        tbl[0]  = '{4'hF, 1'b1, 32'h060F030B, 4'b0001};
        tbl[1]  = '{4'hF, 1'b1, 32'h060F030B, 4'b0010};
        tbl[2]  = '{4'hF, 1'b1, 32'h060F030B, 4'b0100};
        tbl[3]  = '{4'hF, 1'b1, 32'h060F030B, 4'b1000};
        tbl[4]  = '{4'hF, 1'b1, 32'h060F030B, 4'b0001};
        tbl[5]  = '{4'hF, 1'b1, 32'h060F030B, 4'b0010};
        tbl[6]  = '{4'hF, 1'b0, 32'h060F030B, 4'b0000};
        tbl[7]  = '{4'hF, 1'b0, 32'h060F030B, 4'b0000};
        tbl[8]  = '{4'hF, 1'b0, 32'h060F030B, 4'b0000};
        tbl[9]  = '{4'hF, 1'b0, 32'h060F030B, 4'b0000};
        tbl[10] = '{4'hF, 1'b0, 32'h060F030B, 4'b0000};
        tbl[11] = '{4'hF, 1'b1, 32'h060F030B, 4'b0100};
        tbl[12] = '{4'h9, 1'b1, 32'h060F030B, 4'b1000};
        tbl[13] = '{4'h9, 1'b1, 32'h060F030B, 4'b0001};
        tbl[14] = '{4'h1, 1'b1, 32'h060F030B, 4'b0001};
        tbl[15] = '{4'h4, 1'b1, 32'h060F030B, 4'b0100};
        tbl[16] = '{4'h0, 1'b1, 32'h060F030B, 4'b0000};
        tbl[17] = '{4'h0, 1'b0, 32'h060F030B, 4'b0000};
        tbl[18] = '{4'h0, 1'b1, 32'h060F030B, 4'b0000};
        tbl[19] = '{4'h4, 1'b1, 32'h00A50000, 4'b0100};
        tbl[20] = '{4'h4, 1'b1, 32'h00A50000, 4'b0100};
        tbl[21] = '{4'h4, 1'b1, 32'h00A50000, 4'b0100};
        tbl[22] = '{4'h4, 1'b1, 32'h00A50000, 4'b0100};
        tbl[23] = '{4'h4, 1'b1, 32'h00A50000, 4'b0100};

        rst_n     = 1'b0;
        req_valid = 4'h0;
        req_data  = 32'h0;
        out_ready = 1'b0;
        m_ptr     = 2'd0;
        m_sel     = 2'd0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_out_src", 32'(out_src), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        req_valid = 4'hF;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = 4'h0;
        #3;
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            tick(tbl[i].rv, tbl[i].ord, tbl[i].d);
            chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
        end
        chk("drain_sel_held", 32'(m_sel), 32'd2);

        for (int i = 0; i < 300; i++) begin
            tick(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), $urandom());
        end

        // async reset while the output stage holds a word
        tick(4'hF, 1'b0, 32'h44332211);
        tick(4'hF, 1'b0, 32'h44332211);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sel", 32'(sel), 32'd0);
        chk("mid_rst_out_src", 32'(out_src), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = 4'h0;
        q.delete();
        m_ptr = 2'd0;
        m_sel = 2'd0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        tick(4'hC, 1'b1, 32'h44332211);
        chk("post_rst_grant", 32'(req_ready), 32'h4);
        tick(4'h0, 1'b1, 32'h0);
        tick(4'h0, 1'b0, 32'h0);
        chk("final_empty", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
